// File: rtl/status_register_stack.sv
// status_register_stack
// Condition-flag register {N,Z,C,V} fed from the ALU, with a DEPTH-entry LIFO
// of saved flag sets for call/interrupt save-restore, and a branch-condition
// evaluator working on the registered flags.
// Optional build macro: SR_STICKY_OVF_EN adds a sticky overflow flag that is
// cleared by clrSticky. Without it stickyV is tied low and clrSticky is ignored.

module status_register_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] aluResult,
    input  logic             carryIn,
    input  logic             ovfIn,
    input  logic             SRw,
    input  logic             push,
    input  logic             pop,
    input  logic             clrSticky,
    input  logic [2:0]       cond,
    output logic [3:0]       flags,
    output logic             condTrue,
    output logic [PW-1:0]    stackCount,
    output logic             stackFull,
    output logic             stackEmpty,
    output logic             stackErr,
    output logic             stickyV
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    flags_q, flags_d;
    logic [PW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [3:0]    stack_q [DEPTH];

    logic [3:0]    aluFlags;
    logic          isFull, isEmpty;
    logic          pushOnly, popOnly;
    logic [IW-1:0] pushIdx, popIdx;

    assign aluFlags = {aluResult[WIDTH-1], (aluResult == '0), carryIn, ovfIn};
    assign isFull   = (count_q == PW'(DEPTH));
    assign isEmpty  = (count_q == '0);
    assign pushOnly = push & ~pop;
    assign popOnly  = pop & ~push;
    assign pushIdx  = IW'(count_q);
    assign popIdx   = IW'(count_q - PW'(1));

    // Next-state for flags, stack depth and the stack error bit; pop beats SRw.
    always_comb begin
        flags_d = flags_q;
        count_d = count_q;
        err_d   = err_q;
        if (pushOnly) begin
            if (!isFull) begin
                count_d = count_q + PW'(1);
            end else begin
                err_d = 1'b1;
            end
            if (SRw) begin
                flags_d = aluFlags;
            end
        end else if (popOnly) begin
            if (!isEmpty) begin
                flags_d = stack_q[popIdx];
                count_d = count_q - PW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (SRw) begin
            flags_d = aluFlags;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            flags_q <= 4'b0000;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack storage saves the pre-update flags; contents need no reset.
    always_ff @(posedge CLK) begin
        if (!reset && pushOnly && !isFull) begin
            stack_q[pushIdx] <= flags_q;
        end
    end

`ifdef SR_STICKY_OVF_EN
    logic sticky_q;

    // Sticky overflow: a set in the same cycle as a clear wins.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (SRw && ovfIn && !pop) begin
            sticky_q <= 1'b1;
        end else if (clrSticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign stickyV = sticky_q;
`else
    logic unusedClrSticky;
    assign unusedClrSticky = clrSticky;
    assign stickyV         = 1'b0;
`endif

    // Branch condition decode on the registered flags only, no bypass.
    always_comb begin
        condTrue = 1'b0;
        case (cond)
            3'b000: condTrue = 1'b1;
            3'b001: condTrue = flags_q[2];
            3'b010: condTrue = ~flags_q[2];
            3'b011: condTrue = flags_q[3] ^ flags_q[0];
            3'b100: condTrue = ~(flags_q[3] ^ flags_q[0]);
            3'b101: condTrue = ~flags_q[2] & ~(flags_q[3] ^ flags_q[0]);
            3'b110: condTrue = flags_q[2] | (flags_q[3] ^ flags_q[0]);
            3'b111: condTrue = flags_q[1];
            default: condTrue = 1'b0;
        endcase
    end

    assign flags      = flags_q;
    assign stackCount = count_q;
    assign stackFull  = isFull;
    assign stackEmpty = isEmpty;
    assign stackErr   = err_q;

endmodule
